counter_sequencer: RTL

- Controller that sequences a parameterized up-counter with BCD/7-segment output.
- Turns three raw push-buttons into a load / run / pause / terminal-count flow.
- Drives the counter's reset, initial_value and enable (cont) inputs, and watches its count output.
- Sits between the board buttons/switches and the counter instance in the top level.

---
 rtl/counter_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// Button-driven load/run/pause/done sequencer for a parameterized up-counter.
// Optional per-button debounce filter enabled by defining CTRL_DEBOUNCE_EN.
module counter_sequencer #(
    parameter int unsigned N         = 6,
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         btn_start,
    input  logic         btn_stop,
    input  logic         btn_load,
    input  logic [N-1:0] load_value,
    input  logic [N-1:0] limit,
    input  logic [N-1:0] cnt_count,
    output logic         cnt_reset,
    output logic [N-1:0] cnt_initial_value,
    output logic         cnt_enable,
    output logic [2:0]   state,
    output logic         done
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_param_check
        $error("counter_sequencer: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Button bit order: [0] start, [1] stop, [2] load
    logic [2:0] btn_raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] level;
    logic [2:0] edge_q;
    logic [2:0] strobe;

    assign btn_raw = {btn_load, btn_stop, btn_start};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef CTRL_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [2:0]     filt_q;
    logic [DBW-1:0] db_cnt_q [3];

    // Filtered level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        filt_q[i]   <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= level;
        end
    end

    assign strobe = level & ~edge_q;

    logic start_stb;
    logic stop_stb;
    logic load_stb;

    assign start_stb = strobe[0];
    assign stop_stb  = strobe[1];
    assign load_stb  = strobe[2];

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [N-1:0]  init_q, init_d;
    logic          rst_q, rst_d;
    logic          en_q, en_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            init_q  <= '0;
            rst_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            init_q  <= init_d;
            rst_q   <= rst_d;
            en_q    <= en_d;
        end
    end

    // Enable is only issued when staying in RUN, so reset and enable never overlap.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        init_d  = init_q;
        en_d    = 1'b0;
        rst_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_stb) begin
                    init_d  = load_value;
                    state_d = S_LOAD;
                end else if (start_stb) begin
                    pre_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (cnt_count == limit) begin
                    state_d = S_DONE;
                end else if (load_stb) begin
                    init_d  = load_value;
                    state_d = S_LOAD;
                end else if (stop_stb) begin
                    state_d = S_PAUSE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    en_d  = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (load_stb) begin
                    init_d  = load_value;
                    state_d = S_LOAD;
                end else if (start_stb) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (load_stb) begin
                    init_d  = load_value;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rst_d = (state_d == S_LOAD);
    end

    assign cnt_reset         = rst_q;
    assign cnt_enable        = en_q;
    assign cnt_initial_value = init_q;
    assign state             = state_q;
    assign done              = (state_q == S_DONE);

endmodule
